// File: rtl/zigbee_pkg.sv
// Shared definitions for the 802.15.4 O-QPSK transmit chip path.
//   PN_CHIPS  : 32-chip PN sequence for each 4-bit data symbol.
//               Bit 31 holds chip c0 and bit 0 holds chip c31, so each
//               entry reads in transmit order from left to right.
//   tx_state_e: chip generator FSM states.
//   NB_P_MIN  : smallest usable chip period. Programmed values below
//               this are raised to it.
package zigbee_pkg;

    localparam int NB_P_MIN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } tx_state_e;

    // Entries 1..7 are entry 0 rotated right by 4*k chips. Entries 8..15
    // are entries 0..7 with the odd chips inverted (xor 0x55555555).
    localparam logic [31:0] PN_CHIPS [16] = '{
        32'hD9C3522E, 32'hED9C3522, 32'h2ED9C352, 32'h22ED9C35,
        32'h522ED9C3, 32'h3522ED9C, 32'hC3522ED9, 32'h9C3522ED,
        32'h8C96077B, 32'hB8C96077, 32'h7B8C9607, 32'h77B8C960,
        32'h077B8C96, 32'h6077B8C9, 32'h96077B8C, 32'hC96077B8
    };

endpackage

// File: rtl/chip_lut.sv
// Combinational symbol-to-chip lookup.
//   i_sym   : 4-bit data symbol.
//   o_chips : its 32-chip PN sequence. Bit 31 holds c0.
module chip_lut
    import zigbee_pkg::*;
(
    input  logic [3:0]  i_sym,
    output logic [31:0] o_chips
);

    assign o_chips = PN_CHIPS[i_sym];

endmodule

// File: rtl/oqpsk_chip_tx.sv
// O-QPSK transmit chip timing generator and spreader.
//   i_clk, i_rst     : clock and synchronous active-low reset.
//   i_nb_P           : clocks per rail chip. It is latched when each
//                      symbol is loaded, and values below 2 act as 2.
//   i_sym, i_sym_valid / o_sym_ready : symbol input. A transfer happens
//                      on any edge where valid and ready are both high.
//                      Ready is high whenever the one-entry holding
//                      register is empty.
//   o_chip_i, o_en_i : even chips and the strobe that marks each new one.
//   o_chip_q, o_en_q : odd chips, offset by floor(period/2) clocks.
//   o_sym_start      : marks the I strobe that carries chip c0.
//   o_busy           : high while the FSM is active or a symbol is held.
module oqpsk_chip_tx
    import zigbee_pkg::*;
#(
    parameter int NB_P_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NB_P_W-1:0] i_nb_P,
    input  logic [3:0]        i_sym,
    input  logic              i_sym_valid,
    output logic              o_sym_ready,
    output logic              o_chip_i,
    output logic              o_chip_q,
    output logic              o_en_i,
    output logic              o_en_q,
    output logic              o_sym_start,
    output logic              o_busy
);

    localparam logic [NB_P_W-1:0] ONE    = NB_P_W'(1);
    localparam logic [NB_P_W-1:0] NB_MIN = NB_P_W'(NB_P_MIN);

    tx_state_e         state_q, state_d;
    logic              hold_valid_q, hold_valid_d;
    logic [3:0]        hold_sym_q, hold_sym_d;
    logic [NB_P_W-1:0] cnt_q, cnt_d;
    logic [NB_P_W-1:0] nb_lat_q, nb_lat_d;
    logic [NB_P_W-1:0] half_q, half_d;
    logic [3:0]        pair_q, pair_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              chip_i_q, chip_i_d;
    logic              chip_q_q, chip_q_d;
    logic              en_i_q, en_i_d;
    logic              en_q_q, en_q_d;
    logic              sym_start_q, sym_start_d;

    logic [31:0]       lut_chips;
    logic              cnt_last;
    logic              sym_last;
    logic              load;

    chip_lut u_chip_lut (
        .i_sym   (hold_sym_q),
        .o_chips (lut_chips)
    );

    assign cnt_last = (cnt_q == nb_lat_q - ONE);
    assign sym_last = cnt_last && (pair_q == 4'd15);
    // A held symbol is loaded from IDLE. It is also loaded on the last
    // cycle of a running symbol, which keeps the chip stream gapless.
    assign load     = hold_valid_q && ((state_q == IDLE) || ((state_q == RUN) && sym_last));

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hold_valid_q) state_d = RUN;
            RUN:  if (sym_last && !hold_valid_q) state_d = TAIL;
            TAIL: if (cnt_q == half_q - ONE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic. Outputs are computed from the next counter
    // values, so a strobe is visible in the same cycle the counter
    // reaches its phase.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_sym_d   = hold_sym_q;
        cnt_d        = cnt_q;
        nb_lat_d     = nb_lat_q;
        half_d       = half_q;
        pair_d       = pair_q;
        shreg_d      = shreg_q;
        chip_i_d     = chip_i_q;
        chip_q_d     = chip_q_q;
        en_i_d       = 1'b0;
        en_q_d       = 1'b0;
        sym_start_d  = 1'b0;

        if (load) begin
            hold_valid_d = 1'b0;
        end else if (i_sym_valid && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_sym_d   = i_sym;
        end

        if (load) begin
            nb_lat_d    = (i_nb_P < NB_MIN) ? NB_MIN : i_nb_P;
            half_d      = nb_lat_d >> 1;
            cnt_d       = '0;
            pair_d      = 4'd0;
            chip_i_d    = lut_chips[31];
            shreg_d     = lut_chips << 1;
            en_i_d      = 1'b1;
            sym_start_d = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (cnt_last) begin
                        cnt_d = '0;
                        if (pair_q != 4'd15) begin
                            pair_d   = pair_q + 4'd1;
                            chip_i_d = shreg_q[31];
                            shreg_d  = shreg_q << 1;
                            en_i_d   = 1'b1;
                        end else begin
                            // Entering TAIL. The I rail goes quiet while
                            // c31 finishes on Q.
                            chip_i_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                        if (cnt_q + ONE == half_q) begin
                            chip_q_d = shreg_q[31];
                            shreg_d  = shreg_q << 1;
                            en_q_d   = 1'b1;
                        end
                    end
                end
                TAIL: begin
                    if (cnt_q == half_q - ONE) begin
                        cnt_d    = '0;
                        chip_q_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            hold_valid_q <= 1'b0;
            hold_sym_q   <= 4'd0;
            cnt_q        <= '0;
            nb_lat_q     <= '0;
            half_q       <= '0;
            pair_q       <= 4'd0;
            shreg_q      <= 32'd0;
            chip_i_q     <= 1'b0;
            chip_q_q     <= 1'b0;
            en_i_q       <= 1'b0;
            en_q_q       <= 1'b0;
            sym_start_q  <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_sym_q   <= hold_sym_d;
            cnt_q        <= cnt_d;
            nb_lat_q     <= nb_lat_d;
            half_q       <= half_d;
            pair_q       <= pair_d;
            shreg_q      <= shreg_d;
            chip_i_q     <= chip_i_d;
            chip_q_q     <= chip_q_d;
            en_i_q       <= en_i_d;
            en_q_q       <= en_q_d;
            sym_start_q  <= sym_start_d;
        end
    end

    assign o_sym_ready = !hold_valid_q;
    assign o_chip_i    = chip_i_q;
    assign o_chip_q    = chip_q_q;
    assign o_en_i      = en_i_q;
    assign o_en_q      = en_q_q;
    assign o_sym_start = sym_start_q;
    assign o_busy      = (state_q != IDLE) || hold_valid_q;

endmodule

// File: tb/tb_oqpsk_chip_tx.sv
// Testbench for oqpsk_chip_tx. The reference model predicts every output
// on every cycle of a burst from symbol timing arithmetic and from chip
// sequences derived from the base PN sequence.
module tb_oqpsk_chip_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] nb_p;
    logic [3:0] sym;
    logic       sym_valid;
    logic       sym_ready, chip_i, chip_q, en_i, en_q, sym_start, busy;

    int n_checks = 0;
    int n_errors = 0;

    // Current burst, used by the model
    int ph_nsym;
    int ph_sym [3];
    int ph_raw [3];
    int ph_len [3];
    int ph_rst;

    always #5 clk = ~clk;

    oqpsk_chip_tx #(.NB_P_W(6)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_nb_P      (nb_p),
        .i_sym       (sym),
        .i_sym_valid (sym_valid),
        .o_sym_ready (sym_ready),
        .o_chip_i    (chip_i),
        .o_chip_q    (chip_q),
        .o_en_i      (en_i),
        .o_en_q      (en_q),
        .o_sym_start (sym_start),
        .o_busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Chip n of symbol s, built from the base sequence by rotation and
    // odd-chip inversion.
    function automatic logic ref_chip(int s, int n);
        logic [31:0] base;
        int src;
        logic b;
        base = 32'b11011001110000110101001000101110; // c0 is the MSB
        src  = (n - 4 * (s % 8) + 32) % 32;
        b    = base[31 - src];
        if (s >= 8 && (n % 2) == 1) b = ~b;
        return b;
    endfunction

    // Expected {chip_i, chip_q, en_i, en_q, sym_start, ready, busy}.
    // t = 0 is the first cycle after the first load edge.
    function automatic logic [6:0] model_at(int t);
        int s, u, l, h, p, r;
        logic ci, cq, rdy;
        if (ph_rst >= 0 && t > ph_rst) return 7'b0000010;
        if (t < 0) return 7'b0000001;
        s = 0;
        for (int j = 0; j < ph_nsym; j++) begin
            l = ph_len[j];
            if (t < s + 16 * l) begin
                u  = t - s;
                h  = l / 2;
                p  = u / l;
                r  = u % l;
                ci = ref_chip(ph_sym[j], 2 * p);
                if (r >= h)      cq = ref_chip(ph_sym[j], 2 * p + 1);
                else if (p > 0)  cq = ref_chip(ph_sym[j], 2 * p - 1);
                else if (j > 0)  cq = ref_chip(ph_sym[j-1], 31);
                else             cq = 1'b0;
                rdy = (j == ph_nsym - 1) ? 1'b1 : (u == 0);
                return {ci, cq, r == 0, r == h, u == 0, rdy, 1'b1};
            end
            s += 16 * l;
        end
        if (t < s + ph_len[ph_nsym-1] / 2)
            return {1'b0, ref_chip(ph_sym[ph_nsym-1], 31), 3'b000, 1'b1, 1'b1};
        return 7'b0000010;
    endfunction

    task automatic run_phase(input string name, input int nsym,
                             input int s0, input int s1, input int s2,
                             input int r0, input int r1, input int r2,
                             input bit scramble, input int rst_at);
        int total, ncyc, sym_idx, t, acc, jj, uu;
        ph_nsym = nsym;
        ph_sym  = '{s0, s1, s2};
        ph_raw  = '{r0, r1, r2};
        ph_rst  = rst_at;
        total   = 0;
        for (int j = 0; j < 3; j++) ph_len[j] = (ph_raw[j] < 2) ? 2 : ph_raw[j];
        for (int j = 0; j < nsym; j++) total += 16 * ph_len[j];
        ncyc    = (rst_at >= 0) ? rst_at + 8 : total + ph_len[nsym-1] / 2 + 6;
        sym_idx = 0;
        nb_p    = 6'(r0);
        for (int n = 0; n <= ncyc + 1; n++) begin
            @(negedge clk);
            t = n - 2;
            if (n >= 1)
                check($sformatf("%s t=%0d", name, t),
                      {chip_i, chip_q, en_i, en_q, sym_start, sym_ready, busy},
                      model_at(t));
            if (rst_at >= 0 && t == rst_at) begin
                rst     = 1'b0;
                sym_idx = nsym;
            end
            if (rst_at >= 0 && t == rst_at + 1) rst = 1'b1;
            if (sym_idx < nsym) begin
                sym_valid = 1'b1;
                sym       = 4'(ph_sym[sym_idx]);
                if (sym_ready) sym_idx++;
            end else begin
                sym_valid = 1'b0;
                sym       = 4'($urandom_range(0, 15));
            end
            // Disturb the period input mid-symbol. Then present the next
            // symbol's period well before its load.
            if (t >= 0 && t < total) begin
                acc = 0;
                jj  = 0;
                while (t >= acc + 16 * ph_len[jj]) begin
                    acc += 16 * ph_len[jj];
                    jj++;
                end
                uu = t - acc;
                if (scramble && uu == 3) nb_p = 6'($urandom_range(0, 63));
                if (uu == 20 && jj + 1 < nsym) nb_p = 6'(ph_raw[jj+1]);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        sym_valid = 1'b0;
        sym       = 4'd0;
        nb_p      = 6'd4;
        repeat (3) @(negedge clk);
        check("reset ready", sym_ready, 1'b1);
        check("reset outputs", {chip_i, chip_q, en_i, en_q, sym_start, busy}, 6'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle outputs", {chip_i, chip_q, en_i, en_q, sym_start, sym_ready, busy}, 7'b0000010);

        run_phase("p4_sym0",   1, 0, 0, 0,  4, 4, 4, 1'b0, -1);
        run_phase("b2b_3_12",  2, 3, 12, 0, 4, 4, 4, 1'b0, -1);
        run_phase("p5",        1, 7, 0, 0,  5, 5, 5, 1'b0, -1);
        run_phase("p0",        1, 9, 0, 0,  0, 0, 0, 1'b0, -1);
        run_phase("p1",        1, 9, 0, 0,  1, 1, 1, 1'b0, -1);
        run_phase("p2",        1, 9, 0, 0,  2, 2, 2, 1'b0, -1);
        run_phase("nb_change", 2, 0, 5, 0,  4, 8, 8, 1'b0, -1);
        run_phase("rst_mid",   2, 0, 1, 0,  4, 4, 4, 1'b0, 30);
        run_phase("after_rst", 1, 6, 0, 0,  4, 4, 4, 1'b0, -1);
        run_phase("sym8",      1, 8, 0, 0,  4, 4, 4, 1'b0, -1);
        run_phase("b2b3_odd",  3, 15, 2, 11, 3, 7, 2, 1'b1, -1);
        for (int k = 0; k < 4; k++) begin
            run_phase($sformatf("rand%0d", k), int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
